// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO APB arbiter: register map,
// FSM state encoding and command legality check.
package gpio_pkg;

    localparam logic [7:0] GPIO_DIR = 8'h00;
    localparam logic [7:0] GPIO_SET = 8'h04;
    localparam logic [7:0] GPIO_CLR = 8'h08;
    localparam logic [7:0] GPIO_IN  = 8'h0C;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // DIR/SET/CLR are write-only, IN is read-only.
    function automatic logic cmd_legal(
        input logic [7:0] addr,
        input logic       write
    );
        if (write) begin
            return (addr == GPIO_DIR) ||
                   (addr == GPIO_SET) ||
                   (addr == GPIO_CLR);
        end
        return addr == GPIO_IN;
    endfunction

endpackage

// File: rtl/gpio_apb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the
// requester served last and resets so that m0 wins first.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (advance) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/gpio_apb_arbiter.sv
// Two-requester APB master for the GPIO block: round-robin
// grant, SETUP/ACCESS sequencing, per-port read data and done.
module gpio_apb_arbiter
    import gpio_pkg::*;
#(
    parameter int ACCESS_CYCLES = 3
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        m0_valid,
    input  logic        m0_write,
    input  logic [7:0]  m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ready,
    output logic        m0_done,
    output logic        m0_err,
    output logic [15:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_write,
    input  logic [7:0]  m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ready,
    output logic        m1_done,
    output logic        m1_err,
    output logic [15:0] m1_rdata,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [7:0]  PADDR,
    output logic [15:0] PWDATA,
    input  logic [15:0] PRDATA,
    output logic        busy,
    output logic        owner
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [7:0]    addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          owner_q, owner_d;
    logic          err_q, err_d;
    logic [15:0]   rdata0_q, rdata0_d;
    logic [15:0]   rdata1_q, rdata1_d;

    logic [1:0]    grant;
    logic          handshake;
    logic          win;
    logic          sel_write;
    logic [7:0]    sel_addr;
    logic [15:0]   sel_wdata;

    rr_arb2 u_arb (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .req     ({m1_valid, m0_valid}),
        .advance (handshake),
        .grant   (grant)
    );

    assign m0_ready  = m0_valid & grant[0] & (state_q == S_IDLE);
    assign m1_ready  = m1_valid & grant[1] & (state_q == S_IDLE);
    assign handshake = m0_ready | m1_ready;
    assign win       = m1_ready;

    always_comb begin
        sel_write = win ? m1_write : m0_write;
        sel_addr  = win ? m1_addr  : m0_addr;
        sel_wdata = win ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            owner_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            owner_q  <= owner_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        owner_d  = owner_q;
        err_d    = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    write_d = sel_write;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    owner_d = win;
                    if (cmd_legal(sel_addr, sel_write)) begin
                        err_d   = 1'b0;
                        state_d = S_SETUP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                        // Illegal reads report zero data.
                        if (!sel_write && win) rdata1_d = '0;
                        if (!sel_write && !win) rdata0_d = '0;
                    end
                end
            end
            S_SETUP: begin
                cnt_d   = CW'(ACCESS_CYCLES - 1);
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (!write_q && owner_q) rdata1_d = PRDATA;
                    if (!write_q && !owner_q) rdata0_d = PRDATA;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        PSEL     = (state_q == S_SETUP) || (state_q == S_ACCESS);
        PENABLE  = (state_q == S_ACCESS);
        PWRITE   = write_q;
        PADDR    = addr_q;
        PWDATA   = wdata_q;
        busy     = (state_q != S_IDLE);
        owner    = owner_q;
        m0_done  = (state_q == S_DONE) & ~owner_q;
        m1_done  = (state_q == S_DONE) & owner_q;
        m0_err   = m0_done & err_q;
        m1_err   = m1_done & err_q;
        m0_rdata = rdata0_q;
        m1_rdata = rdata1_q;
    end

endmodule

// File: doc/gpio_apb_arbiter.md
# gpio_apb_arbiter

Two-port APB master that shares the 16-bit GPIO peripheral between two requesters, e.g. the CPU bridge and a pin-pattern sequencer. It arbitrates round-robin and sequences each accepted command through the APB SETUP/ACCESS phases. Read data is captured from PRDATA, and completion is reported back to the winning requester with a one-cycle done pulse. The block sits between the requesters and the GPIO slave's PSEL/PWrite/PADDR/PWDATA/PRDATA pins.

## Interface
Parameters:
- ACCESS_CYCLES, 3, cycles PSEL+PENABLE are held per transfer. Minimum 1. The default covers the GPIO slave's registered state plus registered PRDATA.

Ports:
- PCLK  in  1  clock, all logic on the rising edge
- PRESETn  in  1  reset; asynchronous, active-low
- m0_valid, m1_valid  in  1  command request
- m0_write, m1_write  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  8  GPIO register offset
- m0_wdata, m1_wdata  in  16  write data
- m0_ready, m1_ready  out  1  command accepted this cycle
- m0_done, m1_done  out  1  one-cycle completion pulse
- m0_err, m1_err  out  1  qualifies done; illegal command, no bus transfer made
- m0_rdata, m1_rdata  out  16  read result, valid with done, held until the next done on that port
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  8  APB address
- PWDATA  out  16  APB write data
- PRDATA  in  16  APB read data
- busy  out  1  state != IDLE
- owner  out  1  requester of the current or last transfer

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- **IDLE:**
  - Round-robin pick among the valid requesters. With both valid, the one not last served wins. After reset, last = 1, so m0 wins first.
  - Ready is combinational: mX_ready = mX_valid & grant_X & (state == IDLE). At most one ready is high.
  - On handshake: latch write/addr/wdata and owner, update the last pointer, then check legality.
    - Legal command → SETUP.
    - Illegal command → DONE with err.
- **Legal commands:**
  - write to 0x00 (DIR), 0x04 (SET), 0x08 (CLR)
  - read from 0x0C (IN)
  - Anything else is illegal.
- **SETUP:** PSEL=1, PENABLE=0, one cycle → ACCESS.
- **ACCESS:**
  - PSEL=1, PENABLE=1, held ACCESS_CYCLES cycles, counted by a down-counter.
  - On the last ACCESS edge, a read captures PRDATA into the owner's rdata → DONE.
- **DONE:**
  - owner's done=1 for one cycle. err=1 only for illegal commands; an illegal read returns rdata=0.
  - → IDLE.
  - No new handshake occurs in DONE, so there is one idle cycle minimum between transfers.
- A requester may drop valid before ready with no effect. After acceptance its command inputs are don't-care.
- The non-owner's done/err stay 0. Its rdata is unchanged.
- PADDR/PWDATA/PWRITE come from the latched command register and hold their values after a transfer ends.

## Timing
- Reset (asynchronous, immediate) values:
  - state = IDLE, counter = 0, last = 1
  - PSEL, PENABLE, PWRITE = 0; PADDR = 0; PWDATA = 0
  - all ready/done/err = 0, both rdata = 0
  - busy = 0, owner = 0
- Reset mid-transfer aborts it. No done is issued, and the requester must reissue.
- Legal transfer latency from the handshake edge: SETUP 1 + ACCESS ACCESS_CYCLES + DONE 1. With the default that is 5 cycles to the done pulse.
- Illegal command: done+err on the cycle after the handshake. PSEL never asserts.
- Back-to-back: the next handshake can be in the IDLE cycle right after DONE.
- Arbitration is fair under continuous contention: grants strictly alternate between m0 and m1.

## Structure
- Shared package gpio_pkg holds:
  - offsets GPIO_DIR=8'h00, GPIO_SET=8'h04, GPIO_CLR=8'h08, GPIO_IN=8'h0C
  - the state encoding for IDLE/SETUP/ACCESS/DONE
  - a legality function (addr, write) → bit
- One sub-module, rr_arb2: inputs req[1:0] and an advance strobe, output a one-hot grant with the internal last pointer. Reset gives m0 priority.
- The top level holds the FSM, the access counter, the command latch and the rdata registers.

## Test plan
- Reset then m0 write 0x00 data 0xFFFF → m0_ready same cycle. PSEL rises next cycle. PENABLE is high 3 cycles with PADDR=0x00, PWDATA=0xFFFF. m0_done at cycle 5, err=0.
- m1 read 0x0C while PRDATA=0xA5C3 → m1_done with m1_rdata=0xA5C3. m0_rdata unchanged.
- m0 and m1 valid continuously, 4 transfers → grants m0, m1, m0, m1. Never two readys in one cycle.
- m0 write to 0x0C, then m1 read from 0x04 → each gets done+err the cycle after its handshake. PSEL stays 0. m1_rdata=0.
- PRESETn low during ACCESS → PSEL/PENABLE drop immediately, no done. After release, m0 wins the next arbitration.
- ACCESS_CYCLES=1 build, read 0x0C → done 3 cycles after the handshake, PENABLE high exactly 1 cycle.
